// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: return-path tags and
// the full byte-enable constant for the default 32-bit data path.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } arb_tag_e;

  localparam int ARB_DW = 32;
  localparam logic [ARB_DW/8-1:0] SEL_ALL = '1;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of return tags; the tail names the port that
// owns the memory read data arriving this cycle.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     clr,
  input  arb_tag_e tag_in,
  output arb_tag_e tag_out
);

  arb_tag_e stage [RD_LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= TAG_NONE;
    end else begin
      // NOTE: non-blocking so every stage shifts from its pre-edge neighbour.
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// data port: data has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW/8-1:0] d_sel_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [DW-1:0]   d_rdata_o,
  output logic            ram_ce_o,
  output logic            ram_we_o,
  output logic [AW-1:0]   ram_addr_o,
  output logic [DW/8-1:0] ram_sel_o,
  output logic [DW-1:0]   ram_data_o,
  input  logic [DW-1:0]   ram_data_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       if_win;
  logic       d_win;
  arb_tag_e   issue_tag;
  arb_tag_e   tail_tag;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    if_win     = 1'b0;
    d_win      = 1'b0;
    issue_tag  = TAG_NONE;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;

    if (!rst) begin
      if (if_req_i && d_req_i) begin
        if (starve_cnt == STARVE_LIM) if_win = 1'b1;
        else                          d_win  = 1'b1;
      end else begin
        if_win = if_req_i;
        d_win  = d_req_i;
      end
    end

    if (d_win) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = d_we_i;
      ram_addr_o = d_addr_i;
      ram_sel_o  = d_sel_i;
      ram_data_o = d_wdata_i;
      issue_tag  = d_we_i ? TAG_NONE : TAG_D;
    end else if (if_win) begin
      ram_ce_o   = 1'b1;
      ram_addr_o = if_addr_i;
      ram_sel_o  = '1;
      issue_tag  = TAG_IF;
    end
  end

  assign if_gnt_o = if_win;
  assign d_gnt_o  = d_win;

  // Counts consecutive fetch denials; at the limit fetch wins the next contention.
  always_ff @(posedge clk) begin
    if (rst)                                           starve_cnt <= '0;
    else if (if_win)                                   starve_cnt <= '0;
    else if (if_req_i && (starve_cnt != STARVE_LIM))   starve_cnt <= starve_cnt + 4'd1;
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .clr     (rst),
    .tag_in  (issue_tag),
    .tag_out (tail_tag)
  );

  assign if_rvalid_o = (tail_tag == TAG_IF);
  assign d_rvalid_o  = (tail_tag == TAG_D);
  assign if_rdata_o  = ram_data_i;
  assign d_rdata_o   = ram_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RD_LAT 1, 2, 3) share one stimulus stream,
// each with its own RAM model; words below 0x100 hold 0xC0DE0000 | word index.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  always #5 clk = ~clk;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [SW-1:0] d_sel;
  logic [DW-1:0] d_wdata;

  logic          if_gnt    [NI];
  logic          if_rvalid [NI];
  logic [DW-1:0] if_rdata  [NI];
  logic          d_gnt     [NI];
  logic          d_rvalid  [NI];
  logic [DW-1:0] d_rdata   [NI];
  logic          ram_ce    [NI];
  logic          ram_we    [NI];
  logic [AW-1:0] ram_addr  [NI];
  logic [SW-1:0] ram_sel   [NI];
  logic [DW-1:0] ram_wdata [NI];
  logic [DW-1:0] ram_rdata [NI];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [DW-1:0] init_word(int i);
    return (i < 64) ? (32'hC0DE_0000 | 32'(i)) : 32'h0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [DW-1:0] mem   [256];
    logic [DW-1:0] rpipe [LAT];

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT), .STARVE_MAX(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_gnt_o    (if_gnt[g]),
      .if_rvalid_o (if_rvalid[g]),
      .if_rdata_o  (if_rdata[g]),
      .d_req_i     (d_req),
      .d_we_i      (d_we),
      .d_addr_i    (d_addr),
      .d_sel_i     (d_sel),
      .d_wdata_i   (d_wdata),
      .d_gnt_o     (d_gnt[g]),
      .d_rvalid_o  (d_rvalid[g]),
      .d_rdata_o   (d_rdata[g]),
      .ram_ce_o    (ram_ce[g]),
      .ram_we_o    (ram_we[g]),
      .ram_addr_o  (ram_addr[g]),
      .ram_sel_o   (ram_sel[g]),
      .ram_data_o  (ram_wdata[g]),
      .ram_data_i  (ram_rdata[g])
    );

    always @(posedge clk) begin
      if (mem_load) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (ram_ce[g] && ram_we[g]) begin
        for (int b = 0; b < SW; b++)
          if (ram_sel[g][b]) mem[ram_addr[g][9:2]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      end
      rpipe[0] <= mem[ram_addr[g][9:2]];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign ram_rdata[g] = rpipe[LAT-1];
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    repeat (n) adv();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h40; d_addr = 32'h80; d_sel = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (if_gnt[0] !== 1'b0 || d_gnt[0] !== 1'b0)
        $display("FAIL reset_gnt c%0d: if_gnt=%b d_gnt=%b want 0 0", c, if_gnt[0], d_gnt[0]);
      else n_pass++;
      n_checks++;
      if (ram_ce[0] !== 1'b0) $display("FAIL reset_ce c%0d: got %b want 0", c, ram_ce[0]);
      else n_pass++;
      if (c > 0) begin
        for (int k = 0; k < NI; k++) begin
          n_checks++;
          if (if_rvalid[k] !== 1'b0 || d_rvalid[k] !== 1'b0)
            $display("FAIL reset_rvalid i%0d c%0d: if=%b d=%b want 0 0", k, c, if_rvalid[k], d_rvalid[k]);
          else n_pass++;
        end
      end
      adv();
    end
    rst = 1'b0;
  endtask

  task automatic test_contention();
    for (int c = 0; c < 10; c++) begin
      logic exp_if;
      exp_if = (c % 5 == 4);
      @(negedge clk);
      n_checks++;
      if (if_gnt[0] !== exp_if || d_gnt[0] !== !exp_if)
        $display("FAIL contention_gnt c%0d: if_gnt=%b d_gnt=%b want %b %b", c, if_gnt[0], d_gnt[0], exp_if, !exp_if);
      else n_pass++;
      n_checks++;
      if (ram_addr[0] !== (exp_if ? 32'h40 : 32'h80))
        $display("FAIL contention_addr c%0d: got %h want %h", c, ram_addr[0], exp_if ? 32'h40 : 32'h80);
      else n_pass++;
      if (exp_if) begin
        n_checks++;
        if (ram_sel[0] !== SEL_ALL || ram_we[0] !== 1'b0 || ram_ce[0] !== 1'b1)
          $display("FAIL contention_fetch_drive c%0d: sel=%h we=%b ce=%b want %h 0 1", c, ram_sel[0], ram_we[0], ram_ce[0], SEL_ALL);
        else n_pass++;
      end
      adv();
    end
    idle(4);
  endtask

  task automatic test_fetch_stream();
    for (int c = 0; c < 5; c++) begin
      if_req  = (c < 3);
      if_addr = 32'(4 * c);
      @(negedge clk);
      if (c < 3) begin
        n_checks++;
        if (if_gnt[0] !== 1'b1) $display("FAIL fetch_gnt c%0d: got %b want 1", c, if_gnt[0]);
        else n_pass++;
      end
      n_checks++;
      if (d_rvalid[0] !== 1'b0) $display("FAIL fetch_d_rvalid c%0d: got %b want 0", c, d_rvalid[0]);
      else n_pass++;
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== (32'hC0DE_0000 | 32'(c - 1)))
          $display("FAIL fetch_ret c%0d: rvalid=%b rdata=%h want 1 %h", c, if_rvalid[0], if_rdata[0], 32'hC0DE_0000 | 32'(c - 1));
        else n_pass++;
      end else if (c == 4) begin
        n_checks++;
        if (if_rvalid[0] !== 1'b0) $display("FAIL fetch_tail c%0d: rvalid=%b want 0", c, if_rvalid[0]);
        else n_pass++;
      end
      adv();
    end
    idle(4);
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_sel = 4'b0011; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (d_gnt[0] !== 1'b1 || ram_we[0] !== 1'b1 || ram_sel[0] !== 4'b0011 || ram_wdata[0] !== 32'hDEADBEEF)
      $display("FAIL wr_drive: gnt=%b we=%b sel=%b data=%h want 1 1 0011 deadbeef", d_gnt[0], ram_we[0], ram_sel[0], ram_wdata[0]);
    else n_pass++;
    adv();
    d_we = 1'b0; d_sel = 4'hF; d_wdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if (d_gnt[0] !== 1'b1 || ram_we[0] !== 1'b0) $display("FAIL rd_drive: gnt=%b we=%b want 1 0", d_gnt[0], ram_we[0]);
    else n_pass++;
    n_checks++;
    if (d_rvalid[0] !== 1'b0 || if_rvalid[0] !== 1'b0)
      $display("FAIL wr_no_rvalid: d=%b if=%b want 0 0", d_rvalid[0], if_rvalid[0]);
    else n_pass++;
    adv();
    d_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'h0000BEEF || if_rvalid[0] !== 1'b0)
      $display("FAIL rd_ret: d_rvalid=%b d_rdata=%h if_rvalid=%b want 1 0000beef 0", d_rvalid[0], d_rdata[0], if_rvalid[0]);
    else n_pass++;
    n_checks++;
    if (ram_ce[0] !== 1'b0 || ram_we[0] !== 1'b0 || ram_addr[0] !== 32'h0 || ram_sel[0] !== 4'h0 || ram_wdata[0] !== 32'h0)
      $display("FAIL idle_drive: ce=%b we=%b addr=%h sel=%h data=%h want all 0", ram_ce[0], ram_we[0], ram_addr[0], ram_sel[0], ram_wdata[0]);
    else n_pass++;
    adv();
    @(negedge clk);
    n_checks++;
    if (d_rvalid[0] !== 1'b0) $display("FAIL rd_tail: d_rvalid=%b want 0", d_rvalid[0]);
    else n_pass++;
    idle(4);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      d_req = (c == 0 || c == 2); d_we = 1'b0;
      d_addr = (c == 0) ? 32'h0C : 32'h1C;
      if_req = (c == 1); if_addr = 32'h18;
      @(negedge clk);
      n_checks++;
      if (d_gnt[0] !== d_req || if_gnt[0] !== if_req)
        $display("FAIL b2b_gnt c%0d: d=%b if=%b want %b %b", c, d_gnt[0], if_gnt[0], d_req, if_req);
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (d_rvalid[0] !== 1'b1 || if_rvalid[0] !== 1'b0 || d_rdata[0] !== 32'hC0DE0003)
          $display("FAIL b2b_ret c1: d_rvalid=%b if_rvalid=%b data=%h want 1 0 c0de0003", d_rvalid[0], if_rvalid[0], d_rdata[0]);
        else n_pass++;
      end else if (c == 2) begin
        n_checks++;
        if (if_rvalid[0] !== 1'b1 || d_rvalid[0] !== 1'b0 || if_rdata[0] !== 32'hC0DE0006)
          $display("FAIL b2b_ret c2: if_rvalid=%b d_rvalid=%b data=%h want 1 0 c0de0006", if_rvalid[0], d_rvalid[0], if_rdata[0]);
        else n_pass++;
      end else if (c == 3) begin
        n_checks++;
        if (d_rvalid[0] !== 1'b1 || if_rvalid[0] !== 1'b0 || d_rdata[0] !== 32'hC0DE0007)
          $display("FAIL b2b_ret c3: d_rvalid=%b if_rvalid=%b data=%h want 1 0 c0de0007", d_rvalid[0], if_rvalid[0], d_rdata[0]);
        else n_pass++;
      end
      adv();
    end
    idle(4);
  endtask

  task automatic test_interleave();
    for (int c = 0; c < 4; c++) begin
      d_req = (c == 0); d_we = 1'b0; d_addr = 32'h10;
      if_req = (c == 1); if_addr = 32'h20;
      @(negedge clk);
      if (c < 2) begin
        n_checks++;
        if (d_gnt[1] !== d_req || if_gnt[1] !== if_req)
          $display("FAIL ilv_gnt c%0d: d=%b if=%b want %b %b", c, d_gnt[1], if_gnt[1], d_req, if_req);
        else n_pass++;
      end else if (c == 2) begin
        n_checks++;
        if (d_rvalid[1] !== 1'b1 || if_rvalid[1] !== 1'b0 || d_rdata[1] !== 32'hC0DE0004)
          $display("FAIL ilv_d_ret: d_rvalid=%b if_rvalid=%b data=%h want 1 0 c0de0004", d_rvalid[1], if_rvalid[1], d_rdata[1]);
        else n_pass++;
      end else begin
        n_checks++;
        if (if_rvalid[1] !== 1'b1 || d_rvalid[1] !== 1'b0 || if_rdata[1] !== 32'hC0DE0008)
          $display("FAIL ilv_if_ret: if_rvalid=%b d_rvalid=%b data=%h want 1 0 c0de0008", if_rvalid[1], d_rvalid[1], if_rdata[1]);
        else n_pass++;
      end
      adv();
    end
    idle(4);
  endtask

  task automatic test_reset_inflight();
    for (int c = 0; c < 10; c++) begin
      rst    = (c == 2);
      d_req  = (c == 0 || c == 2 || c == 6); d_we = 1'b0;
      d_addr = (c == 0) ? 32'h10 : (c == 2) ? 32'h30 : 32'h04;
      if_req = (c == 1); if_addr = 32'h20;
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if (d_gnt[2] !== 1'b0 || if_gnt[2] !== 1'b0 || ram_ce[2] !== 1'b0)
          $display("FAIL rstfl_gnt: d=%b if=%b ce=%b want 0 0 0", d_gnt[2], if_gnt[2], ram_ce[2]);
        else n_pass++;
      end
      if (c >= 2 && c <= 8) begin
        n_checks++;
        if (d_rvalid[2] !== 1'b0 || if_rvalid[2] !== 1'b0)
          $display("FAIL rstfl_rvalid c%0d: d=%b if=%b want 0 0", c, d_rvalid[2], if_rvalid[2]);
        else n_pass++;
      end else if (c == 9) begin
        n_checks++;
        if (d_rvalid[2] !== 1'b1 || if_rvalid[2] !== 1'b0 || d_rdata[2] !== 32'hC0DE0001)
          $display("FAIL rstfl_resume: d_rvalid=%b if_rvalid=%b data=%h want 1 0 c0de0001", d_rvalid[2], if_rvalid[2], d_rdata[2]);
        else n_pass++;
      end
      adv();
    end
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_load = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_sel = '0; d_wdata = '0;
    adv();
    mem_load = 1'b0;
    test_reset();
    test_contention();
    test_fetch_stream();
    test_write_read();
    test_back_to_back();
    test_interleave();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
